// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3b memory arbiter and its round-robin picker.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01
  } state_t;

  localparam int NPORT = 3;

  localparam logic [1:0] PORT_FETCH = 2'd0;
  localparam logic [1:0] PORT_DATA  = 2'd1;
  localparam logic [1:0] PORT_DBG   = 2'd2;

  localparam int DEFAULT_AW = 16;
  localparam int DEFAULT_DW = 16;

  localparam logic [15:0] TIMEOUT_DATA = 16'hFFFF;

endpackage

// File: rtl/lc3_rr_picker.sv
// Combinational round-robin picker: searches last_grant+1, +2, +3 (mod NPORT) for the first request.
module lc3_rr_picker
  import lc3_mem_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  logic [1:0]       last_grant,
  output logic [NPORT-1:0] winner,
  output logic [1:0]       winner_idx,
  output logic             valid
);

  int p;

  // Scan from farthest to nearest so the nearest requester is the last assignment standing.
  always_comb begin
    winner     = '0;
    winner_idx = PORT_FETCH;
    p          = 0;
    for (int k = NPORT; k >= 1; k--) begin
      p = (int'(last_grant) + k) % NPORT;
      if (req[p]) begin
        winner     = '0;
        winner[p]  = 1'b1;
        winner_idx = 2'(p);
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Round-robin owner of the single LC-3b memory port shared by fetch, data and debug requesters.
// Optional wait-timeout with err pulse is enabled by defining LC3_MEM_ARB_TIMEOUT_EN.
module lc3_mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int AW = DEFAULT_AW,
  parameter int DW = DEFAULT_DW
`ifdef LC3_MEM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NPORT-1:0]    req,
  input  logic [NPORT-1:0]    req_rd,
  input  logic [NPORT*AW-1:0] req_addr,
  input  logic [NPORT*DW-1:0] req_wdata,
  output logic [NPORT-1:0]    gnt,
  output logic [NPORT-1:0]    done,
  output logic [DW-1:0]       rdata,
  output logic                mem_req,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_din,
  output logic                mem_rd,
  input  logic [DW-1:0]       mem_dout,
  input  logic                mem_complete,
  output logic                err
);

  state_t           state_reg;
  logic [1:0]       last_grant_reg;
  logic [1:0]       owner_reg;
  logic [NPORT-1:0] pick_winner;
  logic [1:0]       pick_idx;
  logic             pick_valid;

`ifdef LC3_MEM_ARB_TIMEOUT_EN
  logic [7:0]       wait_cnt_reg;
`else
  assign err = 1'b0;
`endif

  lc3_rr_picker u_picker (
    .req        (req),
    .last_grant (last_grant_reg),
    .winner     (pick_winner),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= PORT_DBG;
      owner_reg      <= PORT_FETCH;
      gnt            <= '0;
      done           <= '0;
      mem_req        <= 1'b0;
      mem_rd         <= 1'b1;
      mem_addr       <= '0;
      mem_din        <= '0;
      rdata          <= '0;
`ifdef LC3_MEM_ARB_TIMEOUT_EN
      err            <= 1'b0;
      wait_cnt_reg   <= '0;
`endif
    end else begin
      done <= '0;
`ifdef LC3_MEM_ARB_TIMEOUT_EN
      err  <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            mem_addr  <= req_addr[int'(pick_idx)*AW +: AW];
            mem_din   <= req_wdata[int'(pick_idx)*DW +: DW];
            mem_rd    <= req_rd[pick_idx];
            gnt       <= pick_winner;
            owner_reg <= pick_idx;
            mem_req   <= 1'b1;
            state_reg <= BUSY;
`ifdef LC3_MEM_ARB_TIMEOUT_EN
            wait_cnt_reg <= '0;
`endif
          end
        end
        BUSY: begin
          // Bus fields stay frozen here; only completion (or timeout) ends ownership.
          if (mem_complete) begin
            if (mem_rd) rdata <= mem_dout;
            done           <= gnt;
            gnt            <= '0;
            mem_req        <= 1'b0;
            last_grant_reg <= owner_reg;
            state_reg      <= IDLE;
          end
`ifdef LC3_MEM_ARB_TIMEOUT_EN
          else if (wait_cnt_reg == 8'(TIMEOUT)) begin
            rdata          <= DW'(TIMEOUT_DATA);
            err            <= 1'b1;
            done           <= gnt;
            gnt            <= '0;
            mem_req        <= 1'b0;
            last_grant_reg <= owner_reg;
            state_reg      <= IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
`endif
        end
        default: begin
          gnt       <= '0;
          mem_req   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Scoreboard bench for lc3_mem_arbiter: a transaction-level model predicts grants and completions.
module tb_lc3_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  req = '0, req_rd = '0;
  logic [47:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  gnt, done;
  logic [15:0] rdata, mem_addr, mem_din;
  logic        mem_req, mem_rd, err;
  logic [15:0] mem_dout = '0;
  logic        mem_complete = 1'b0;

  always #5 clock = ~clock;

  lc3_mem_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .req_rd       (req_rd),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .gnt          (gnt),
    .done         (done),
    .rdata        (rdata),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_rd       (mem_rd),
    .mem_dout     (mem_dout),
    .mem_complete (mem_complete),
    .err          (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  typedef struct {
    int          due;
    int          port;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        rd;
    logic [15:0] rdata;
  } exp_t;

  exp_t        gq[$];
  exp_t        dq[$];
  exp_t        e_g, e_d, cur, m_cur;
  bit          have_cur = 0;
  bit          m_busy = 0;
  int          m_last = 2;
  logic [15:0] m_rdata = '0;
  int          cyc = 0;
  logic        prev_req = 1'b0;
  int          grant_log[$];
  int          order[3];
  int          w;

  // Monitor first (outputs from the previous edge), then the model (inputs for the next edge).
  always @(negedge clock) begin
    if (!reset) begin
      check("reset_ctl", {26'b0, gnt, done}, 32'h0);
      check("reset_bus", {29'b0, mem_req, mem_rd, err}, 32'h2);
      check("reset_addr", {16'b0, mem_addr}, 32'h0);
      check("reset_din", {16'b0, mem_din}, 32'h0);
      check("reset_rdata", {16'b0, rdata}, 32'h0);
      gq.delete();
      dq.delete();
      have_cur = 0;
      m_busy   = 0;
      m_last   = 2;
      m_rdata  = '0;
      prev_req = 1'b0;
    end else begin
      if (gq.size() > 0 && gq[0].due == cyc) begin
        e_g = gq.pop_front();
        check("grant_mem_req", {31'b0, mem_req}, 32'h1);
        check("grant_gnt", {29'b0, gnt}, 32'h1 << e_g.port);
        check("grant_addr", {16'b0, mem_addr}, {16'b0, e_g.addr});
        check("grant_din", {16'b0, mem_din}, {16'b0, e_g.wdata});
        check("grant_rd", {31'b0, mem_rd}, {31'b0, e_g.rd});
        cur = e_g;
        have_cur = 1;
        grant_log.push_back(e_g.port);
      end else begin
        check("unexpected_grant", {31'b0, mem_req & ~prev_req}, 32'h0);
        if (have_cur && mem_req) begin
          check("frozen_addr", {16'b0, mem_addr}, {16'b0, cur.addr});
          check("frozen_din", {16'b0, mem_din}, {16'b0, cur.wdata});
          check("frozen_rd", {31'b0, mem_rd}, {31'b0, cur.rd});
          check("frozen_gnt", {29'b0, gnt}, 32'h1 << cur.port);
        end
      end
      if (!mem_req) have_cur = 0;

      if (dq.size() > 0 && dq[0].due == cyc) begin
        e_d = dq.pop_front();
        check("done_port", {29'b0, done}, 32'h1 << e_d.port);
        check("done_rdata", {16'b0, rdata}, {16'b0, e_d.rdata});
        check("done_turnaround", {31'b0, mem_req}, 32'h0);
        $display("txn port=%0d %s addr=%h wdata=%h rdata=%h", e_d.port, e_d.rd ? "RD" : "WR",
                 e_d.addr, e_d.wdata, rdata);
      end else begin
        check("unexpected_done", {29'b0, done}, 32'h0);
      end
      check("done_gnt_overlap", {29'b0, done & gnt}, 32'h0);
      check("err_low", {31'b0, err}, 32'h0);

      if (m_busy) begin
        if (mem_complete) begin
          e_d = m_cur;
          if (m_cur.rd) m_rdata = mem_dout;
          e_d.rdata = m_rdata;
          e_d.due   = cyc + 1;
          dq.push_back(e_d);
          m_last = m_cur.port;
          m_busy = 0;
        end
      end else if (req != 3'b000) begin
        order[0] = (m_last + 1) % 3;
        order[1] = (m_last + 2) % 3;
        order[2] = m_last;
        w = order[2];
        if (req[order[1]]) w = order[1];
        if (req[order[0]]) w = order[0];
        e_g.port  = w;
        e_g.addr  = req_addr[w*16 +: 16];
        e_g.wdata = req_wdata[w*16 +: 16];
        e_g.rd    = req_rd[w];
        e_g.rdata = '0;
        e_g.due   = cyc + 1;
        gq.push_back(e_g);
        m_cur  = e_g;
        m_busy = 1;
      end
      prev_req = mem_req;
    end
    cyc++;
  end

  // Memory responder and random requesters, all driven just after the active edge.
  int          mcnt = 0, cur_lat = 1, fixed_lat = 2;
  bit          rand_lat = 0, spurious_en = 0, auto_req = 0, force_en = 0;
  logic [15:0] force_val = '0;

  task automatic new_fields(input int i);
    req_addr[i*16 +: 16]  = 16'($urandom);
    req_wdata[i*16 +: 16] = 16'($urandom);
    req_rd[i]             = 1'($urandom);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    mem_complete = 1'b0;
    mem_dout = force_en ? force_val : 16'($urandom);
    if (mem_req) begin
      if (mcnt == 0) cur_lat = rand_lat ? int'($urandom_range(1, 5)) : fixed_lat;
      mcnt++;
      if (mcnt == cur_lat) mem_complete = 1'b1;
    end else begin
      mcnt = 0;
      if (spurious_en && $urandom_range(0, 3) == 0) mem_complete = 1'b1;
    end
    if (auto_req) begin
      for (int i = 0; i < 3; i++) begin
        if (done[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else begin
            req[i] = 1'b1;
            new_fields(i);
          end
        end else if (gnt[i]) begin
          if ($urandom_range(0, 7) == 0) new_fields(i);
          if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          new_fields(i);
        end
      end
    end
  endtask

  int exp_order[4] = '{0, 1, 2, 0};

  initial begin
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Reset mid-BUSY with all ports requesting, then rotation after release.
    req_addr  = {16'h3000, 16'h2000, 16'h1000};
    req_wdata = {16'h0333, 16'h0222, 16'h0111};
    req_rd    = 3'b111;
    req       = 3'b111;
    fixed_lat = 1000;
    for (int k = 0; k < 10 && !mem_req; k++) tick();
    check("a_busy_before_reset", {31'b0, mem_req}, 32'h1);
    tick();
    tick();
    #2 reset = 1'b0;
    #1 check("a_async_drop", {28'b0, mem_req, gnt}, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    grant_log.delete();
    fixed_lat = 2;
    repeat (24) tick();
    check("a_grant_count", {31'b0, grant_log.size() >= 4}, 32'h1);
    for (int i = 0; i < 4; i++)
      check("a_rotation", (i < grant_log.size()) ? grant_log[i] : -1, exp_order[i]);
    req = 3'b000;
    repeat (8) tick();

    // Port 1 write, memory completes three cycles after mem_req.
    req_addr[16 +: 16]  = 16'h4000;
    req_wdata[16 +: 16] = 16'hBEEF;
    req_rd[1]           = 1'b0;
    req                 = 3'b010;
    fixed_lat           = 3;
    for (int k = 0; k < 20 && !done[1]; k++) tick();
    check("b_done1", {31'b0, done[1]}, 32'h1);
    req = 3'b000;
    repeat (3) tick();

    // Port 0 read with known return data.
    req_addr[0 +: 16] = 16'h3000;
    req_rd[0]         = 1'b1;
    force_en          = 1;
    force_val         = 16'h1234;
    fixed_lat         = 1;
    req               = 3'b001;
    for (int k = 0; k < 20 && !done[0]; k++) tick();
    check("c_done0", {31'b0, done[0]}, 32'h1);
    check("c_rdata", {16'b0, rdata}, 32'h1234);
    req      = 3'b000;
    force_en = 0;
    repeat (3) tick();

    // Port 2 disturbs its inputs mid-transaction.
    req_addr[32 +: 16] = 16'h5000;
    req_rd[2]          = 1'b1;
    fixed_lat          = 4;
    req                = 3'b100;
    for (int k = 0; k < 20 && !gnt[2]; k++) tick();
    check("d_gnt2", {31'b0, gnt[2]}, 32'h1);
    req_addr[32 +: 16] = 16'hAAAA;
    req[2]             = 1'b0;
    for (int k = 0; k < 20 && !done[2]; k++) tick();
    check("d_done2", {31'b0, done[2]}, 32'h1);
    repeat (3) tick();

    // Completion strobe while idle must be ignored.
    mem_complete = 1'b1;
    tick();
    tick();
    check("e_idle_quiet", {28'b0, mem_req, done}, 32'h0);

    // Randomized traffic.
    rand_lat    = 1;
    spurious_en = 1;
    auto_req    = 1;
    repeat (4000) tick();
    auto_req    = 0;
    spurious_en = 0;
    req         = 3'b000;
    repeat (20) tick();
    check("drain_grants", gq.size(), 32'h0);
    check("drain_dones", dq.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
- Shares the single LC-3b memory port (addr/din/rd/complete handshake) between three requesters: instruction fetch (port 0), data access (port 1) and debug/IO loader (port 2).
- Replaces direct tri-state sharing of addr/rd with one registered owner of the memory bus.
- Round-robin arbitration, one outstanding transaction, per-port done pulse with captured read data.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- TIMEOUT, 255, maximum cycles in BUSY waiting for mem_complete (used only with the optional feature).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  3  per-port request; held high until that port's done.
- req_rd  in  3  per-port direction: 1 = read, 0 = write.
- req_addr  in  3*AW  per-port address; port i at [i*AW +: AW].
- req_wdata  in  3*DW  per-port write data.
- gnt  out  3  one-hot; high while the port owns the memory.
- done  out  3  one-cycle pulse when the port's transaction completes.
- rdata  out  DW  read data captured at completion; valid with done, held until the next completion.
- mem_req  out  1  memory access strobe; high for the whole transaction.
- mem_addr  out  AW  memory address.
- mem_din  out  DW  write data to memory.
- mem_rd  out  1  1 = read, 0 = write.
- mem_dout  in  DW  read data from memory.
- mem_complete  in  1  memory completion; sampled only in BUSY.
- err  out  1  timeout pulse (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE.
  - gnt, done, mem_req, err = 0; mem_rd = 1.
  - mem_addr, mem_din, rdata = 0.
  - last_grant = 2, so port 0 wins first after reset.
- States: IDLE, BUSY. Two-bit encoding; unused codes return to IDLE.
- IDLE:
  - If any req bit is set, pick the first requesting port searching last_grant+1, +2, +3 (mod 3).
  - Next edge: latch the winner's addr, wdata and rd into mem_addr, mem_din and mem_rd; set gnt[winner], set mem_req; go to BUSY.
  - Latency from req sampled high to mem_req high: 1 cycle.
- BUSY:
  - mem_addr, mem_din, mem_rd and gnt are frozen; requester input changes are ignored.
  - On mem_complete = 1:
    - next edge: rdata = mem_dout if mem_rd = 1, otherwise unchanged.
    - done[owner] = 1 for one cycle.
    - gnt = 0, mem_req = 0, last_grant = owner; go to IDLE.
- Throughput: at most one transaction per 2 cycles. There is always one IDLE turnaround cycle with mem_req low.
- A requester may drop req after done. If it keeps req high, done is consumed and it competes again at the next arbitration.
- Dropping req mid-transaction does not abort it; done still pulses.
- mem_complete in IDLE is ignored.
- Simultaneous requests from all three ports are served in strict rotation: no port waits more than 2 transactions.
- done and gnt are never high for the same port in the same cycle.
- Reset asserted mid-BUSY:
  - the transaction is abandoned and no done pulse is generated;
  - the memory sees mem_req drop asynchronously.
- All outputs are registered; there is no combinational path from req to mem_*.

Optional Feature:
- Macro: LC3_MEM_ARB_TIMEOUT_EN.
- With the macro defined:
  - an 8-bit wait counter clears on entry to BUSY and increments each BUSY cycle without mem_complete;
  - when the counter reaches TIMEOUT, next edge: done[owner] pulses, rdata = 16'hFFFF, err pulses for one cycle, and the block returns to IDLE;
  - mem_complete in the same cycle as the timeout takes precedence: normal completion, err = 0.
- Without the macro: no counter, err tied 0, BUSY waits indefinitely.

Decomposition:
- Package lc3_mem_pkg:
  - state typedef (IDLE, BUSY);
  - port index constants PORT_FETCH = 0, PORT_DATA = 1, PORT_DBG = 2;
  - NPORT = 3; default AW and DW;
  - TIMEOUT_DATA = 16'hFFFF.
- Sub-module lc3_rr_picker: combinational; takes req[2:0] and last_grant[1:0], returns a one-hot winner and its index. It is reused by the future I/O arbiter.

Test Plan:
- Reset mid-BUSY, then release, with req = 3'b111 -> grants go 0, 1, 2, 0 on successive transactions; no done pulse for the abandoned transaction.
- Port 1 write to addr 16'h4000, data 16'hBEEF; memory completes 3 cycles after mem_req -> mem_rd = 0, mem_din = 16'hBEEF, done[1] pulses 1 cycle after complete; rdata unchanged.
- Port 0 read of 16'h3000, memory returns 16'h1234 -> rdata = 16'h1234 coincident with done[0]; mem_req high exactly 1 cycle after req.
- Port 2 changes req_addr mid-BUSY and drops req -> mem_addr stays at the latched value and done[2] still pulses.
- mem_complete pulsed while IDLE -> no done, no state change.
- With LC3_MEM_ARB_TIMEOUT_EN and TIMEOUT = 4, memory never completes -> err and done pulse after 4 BUSY cycles, rdata = 16'hFFFF, next grant proceeds normally.
